sha256_round_ctrl: RTL



---
 rtl/sha256_round_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: SHA-256 job sequencer (W load, rounds, H accumulate); optional double hash via ROUND_CTRL_DOUBLE_HASH_EN
module sha256_round_ctrl #(
  parameter int ROUNDS   = 64,
  parameter int WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       w_ready,
  output logic       busy,
  output logic       w_en,
  output logic       round_init,
  output logic       round_en,
  output logic [5:0] round_idx,
  output logic       hash_acc,
  output logic       done,
  output logic       timeout,
  output logic       pass
);
  typedef enum logic [2:0] {IDLE, WLOAD, INIT, ROUND, ACC, DONE, TOUT} state_t;
  state_t     state, state_n;
  logic [5:0] rcnt, rcnt_n;
  logic [7:0] wcnt, wcnt_n;
  // state and counters; reset forces IDLE with cleared counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rcnt  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      wcnt  <= wcnt_n;
    end
  end
`ifdef ROUND_CTRL_DOUBLE_HASH_EN
  logic pass_q;
  // second pass starts on leaving ACC; any exit to IDLE returns to the first pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pass_q <= 1'b0;
    else if (state != IDLE && abort) pass_q <= 1'b0;
    else if (state == ACC) pass_q <= 1'b1;
    else if (state == DONE || state == TOUT) pass_q <= 1'b0;
  end
  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif
  // next state; counters default to zero so they only run in their own state
  always_comb begin
    state_n = state;
    rcnt_n  = '0;
    wcnt_n  = '0;
    if (state != IDLE && abort) state_n = IDLE;
    else begin
      case (state)
        IDLE:  state_n = (start && !abort) ? WLOAD : IDLE;
        WLOAD: begin
          state_n = w_ready ? INIT : (wcnt == 8'(WAIT_MAX)) ? TOUT : WLOAD;
          wcnt_n  = (w_ready || wcnt == 8'(WAIT_MAX)) ? 8'd0 : wcnt + 8'd1;
        end
        INIT:  state_n = ROUND;
        ROUND: begin
          state_n = (rcnt == 6'(ROUNDS - 1)) ? ACC : ROUND;
          rcnt_n  = (rcnt == 6'(ROUNDS - 1)) ? 6'd0 : rcnt + 6'd1;
        end
`ifdef ROUND_CTRL_DOUBLE_HASH_EN
        ACC:   state_n = pass ? DONE : WLOAD;
`else
        ACC:   state_n = DONE;
`endif
        default: state_n = IDLE;
      endcase
    end
  end
  assign busy       = state != IDLE;
  assign w_en       = state == WLOAD;
  assign round_init = state == INIT;
  assign round_en   = state == ROUND;
  assign round_idx  = (state == ROUND) ? rcnt : 6'd0;
  assign hash_acc   = state == ACC;
  assign done       = state == DONE;
  assign timeout    = state == TOUT;
endmodule
